// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each access has a fixed latency of WAIT_CYCLES extra cycles and an out-of-range error flag.
module mem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [8:0]  DEPTH_L  = 9'(DEPTH);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [7:0]    addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [15:0]   mem_q [DEPTH];

   logic          enter_resp;
   logic          acc_write;
   logic [7:0]    acc_addr;
   logic [15:0]   acc_wdata;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [15:0]   mem_rd;
   logic          mem_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // With zero wait the access happens on the accept edge, so it uses the live request fields.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      acc_write  = wr_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wr_d      = req_write;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               acc_write = req_write;
               acc_addr  = req_addr;
               acc_wdata = req_wdata;
               if (WAIT_CYCLES == 0) begin
                  enter_resp = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               enter_resp = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_range = ({1'b0, acc_addr} < DEPTH_L);
      idx      = acc_addr[AW-1:0];
      mem_rd   = in_range ? mem_q[idx] : '0;
      mem_we   = enter_resp & acc_write & in_range;
      if (enter_resp) begin
         err_d   = ~in_range;
         rdata_d = !in_range ? '0 : (acc_write ? acc_wdata : mem_rd);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else if (mem_we) begin
         mem_q[idx] <= acc_wdata;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at DEPTH=256/WAIT=2, one at DEPTH=16/WAIT=0.
// Table vectors, reset-abort sequence and randomised traffic against a reference memory.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
   logic [7:0]  a_req_addr;
   logic [15:0] a_req_wdata, a_rsp_rdata;
   logic        b_rst, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
   logic [7:0]  b_req_addr;
   logic [15:0] b_req_wdata, b_rsp_rdata;

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .reset(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err), .busy(a_busy));

   mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .reset(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err), .busy(b_busy));

   typedef struct packed {
      logic        req_ready;
      logic        rsp_valid;
      logic [15:0] rdata;
      logic        err;
      logic        busy;
   } outs_t;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      int          d;
      bit          w;
      logic [7:0]  a;
      logic [15:0] wd;
      int          stall;
      bit          scr;
      logic [15:0] er;
      logic        ee;
   } vec_t;

   int          nvec  = 0;
   int          nfail = 0;
   exp_t        sb[$];
   logic [15:0] ref_m [2][256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int waits(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic int depth(input int d);
      return (d == 0) ? 256 : 16;
   endfunction

   task automatic set_req(input int d, input logic v, input logic w, input logic [7:0] a,
                          input logic [15:0] wd);
      if (d == 0) begin
         a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = wd;
      end else begin
         b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = wd;
      end
   endtask

   task automatic set_rdy(input int d, input logic r);
      if (d == 0) a_rsp_ready = r;
      else        b_rsp_ready = r;
   endtask

   function automatic outs_t get_outs(input int d);
      outs_t o;
      if (d == 0) o = '{a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy};
      else        o = '{b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_busy};
      return o;
   endfunction

   // Model: compute expectation and update reference memory.
   function automatic exp_t model(input int d, input bit w, input logic [7:0] a, input logic [15:0] wd);
      exp_t e;
      if (int'(a) >= depth(d)) begin
         e = '{16'h0000, 1'b1};
      end else if (w) begin
         ref_m[d][a] = wd;
         e = '{wd, 1'b0};
      end else begin
         e = '{ref_m[d][a], 1'b0};
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the consuming edge.
   task automatic xact(input int d, input bit w, input logic [7:0] a, input logic [15:0] wd,
                       input int gap, input int stall, input bit scr, input exp_t e_in);
      outs_t o;
      exp_t  e;
      int    n;
      repeat (gap) begin
         set_rdy(d, scr);
         @(negedge clk);
      end
      set_rdy(d, 1'b0);
      set_req(d, 1'b1, w, a, wd);
      o = get_outs(d);
      n = 0;
      while (!o.req_ready && n < 20) begin
         @(negedge clk);
         o = get_outs(d);
         n++;
      end
      chk("accept_wait", n, 0);
      sb.push_back(e_in);
      @(posedge clk);
      @(negedge clk);
      if (scr) set_req(d, 1'b1, ~w, ~a, ~wd);
      else     set_req(d, 1'b0, 1'b0, 8'h00, 16'h0000);
      o = get_outs(d);
      n = 0;
      while (!o.rsp_valid && n < 50) begin
         chk("wait_ready_low", {31'b0, o.req_ready}, 0);
         chk("wait_busy", {31'b0, o.busy}, 1);
         set_rdy(d, scr);
         @(negedge clk);
         o = get_outs(d);
         n++;
      end
      set_rdy(d, 1'b0);
      chk("latency", n, waits(d));
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      chk("rsp_rdata", {16'b0, o.rdata}, {16'b0, e.rdata});
      chk("rsp_err", {31'b0, o.err}, {31'b0, e.err});
      repeat (stall) begin
         @(negedge clk);
         o = get_outs(d);
         chk("stall_valid", {31'b0, o.rsp_valid}, 1);
         chk("stall_rdata", {16'b0, o.rdata}, {16'b0, e.rdata});
         chk("stall_err", {31'b0, o.err}, {31'b0, e.err});
         chk("stall_ready_low", {31'b0, o.req_ready}, 0);
      end
      set_req(d, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_rdy(d, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_rdy(d, 1'b0);
      o = get_outs(d);
      chk("consumed_valid", {31'b0, o.rsp_valid}, 0);
      chk("consumed_ready", {31'b0, o.req_ready}, 1);
   endtask

   always @(negedge clk) begin
      chk("ready_vs_busy_a", {31'b0, a_req_ready}, {31'b0, ~a_busy});
      chk("ready_vs_busy_b", {31'b0, b_req_ready}, {31'b0, ~b_busy});
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl[$];
      outs_t o;
      exp_t  e;

      tbl.push_back('{0, 1, 8'h10, 16'hBEEF, 0, 0, 16'hBEEF, 1'b0});
      tbl.push_back('{0, 0, 8'h10, 16'h0000, 0, 0, 16'hBEEF, 1'b0});
      tbl.push_back('{0, 0, 8'h05, 16'h0000, 0, 0, 16'h0000, 1'b0});
      tbl.push_back('{0, 1, 8'hFF, 16'h1234, 0, 0, 16'h1234, 1'b0});
      tbl.push_back('{0, 0, 8'hFF, 16'h0000, 0, 0, 16'h1234, 1'b0});
      tbl.push_back('{0, 1, 8'h00, 16'hC0DE, 5, 1, 16'hC0DE, 1'b0});
      tbl.push_back('{0, 0, 8'h00, 16'h0000, 5, 1, 16'hC0DE, 1'b0});
      tbl.push_back('{1, 0, 8'h05, 16'h0000, 0, 0, 16'h0000, 1'b0});
      tbl.push_back('{1, 1, 8'h20, 16'h1234, 0, 0, 16'h0000, 1'b1});
      tbl.push_back('{1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 1'b0});
      tbl.push_back('{1, 0, 8'h20, 16'h0000, 0, 0, 16'h0000, 1'b1});
      tbl.push_back('{1, 1, 8'h0F, 16'h5555, 0, 0, 16'h5555, 1'b0});
      tbl.push_back('{1, 0, 8'h0F, 16'h0000, 2, 1, 16'h5555, 1'b0});
      tbl.push_back('{1, 1, 8'h10, 16'h7777, 0, 0, 16'h0000, 1'b1});
      tbl.push_back('{1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 1'b0});

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) ref_m[d][i] = 16'h0000;

      a_rst = 1'b1; b_rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         o = get_outs(d);
         chk("reset_req_ready", {31'b0, o.req_ready}, 1);
         chk("reset_rsp_valid", {31'b0, o.rsp_valid}, 0);
         chk("reset_rdata", {16'b0, o.rdata}, 0);
         chk("reset_err", {31'b0, o.err}, 0);
         chk("reset_busy", {31'b0, o.busy}, 0);
      end
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) begin
         e = '{tbl[i].er, tbl[i].ee};
         xact(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, 0, tbl[i].stall, tbl[i].scr, e);
         if (tbl[i].w && int'(tbl[i].a) < depth(tbl[i].d)) ref_m[tbl[i].d][tbl[i].a] = tbl[i].wd;
      end

      // Reset in the middle of the wait phase of a store must abort it.
      set_req(0, 1'b1, 1'b1, 8'h03, 16'hAAAA);
      @(posedge clk);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      chk("abort_busy_before", {31'b0, a_busy}, 1);
      a_rst = 1'b1;
      #1;
      chk("abort_rsp_valid", {31'b0, a_rsp_valid}, 0);
      chk("abort_busy", {31'b0, a_busy}, 0);
      chk("abort_req_ready", {31'b0, a_req_ready}, 1);
      chk("abort_rdata", {16'b0, a_rsp_rdata}, 0);
      repeat (2) @(negedge clk);
      a_rst = 1'b0;
      for (int i = 0; i < 256; i++) ref_m[0][i] = 16'h0000;
      repeat (5) begin
         @(negedge clk);
         chk("post_abort_no_rsp", {31'b0, a_rsp_valid}, 0);
      end
      xact(0, 0, 8'h03, 16'h0000, 0, 0, 0, '{16'h0000, 1'b0});
      xact(0, 0, 8'h10, 16'h0000, 0, 0, 0, '{16'h0000, 1'b0});

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 120; i++) begin
            bit          w;
            logic [7:0]  a;
            logic [15:0] wd;
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) a = 8'($urandom_range(0, 255));
            wd = 16'($urandom);
            e  = model(d, w, a, wd);
            xact(d, w, a, wd, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), e);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256; number of 16-bit words implemented, legal range 1..256.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; extra access latency in cycles, legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  8  word address.
REQ-009 SHALL have port req_wdata  input  16  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port rsp_rdata  output  16  load data, or echoed store data.
REQ-013 SHALL have port rsp_err  output  1  request addressed a word at or beyond DEPTH.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_write, req_addr and req_wdata are captured on that edge.
REQ-018 On accept, the FSM SHALL go to WAIT with the counter loaded with WAIT_CYCLES-1 when WAIT_CYCLES>0, or go directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the edge where it reads 0, the FSM SHALL enter RESP.
REQ-020 The memory access SHALL occur on the edge entering RESP, using only the captured request fields.
REQ-021 Latency SHALL be fixed: a request accepted at edge N gives rsp_valid=1 from the cycle after edge N+WAIT_CYCLES.
REQ-022 For a load with captured addr<DEPTH: rsp_rdata SHALL equal mem[addr] and rsp_err SHALL be 0.
REQ-023 For a store with captured addr<DEPTH: mem[addr] SHALL be written with the captured wdata, rsp_rdata SHALL equal wdata, and rsp_err SHALL be 0.
REQ-024 For captured addr>=DEPTH: memory SHALL be unchanged, rsp_rdata SHALL be 0, and rsp_err SHALL be 1.
REQ-025 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL stay stable until the edge where rsp_ready=1; that edge SHALL return the FSM to IDLE and clear rsp_valid.
REQ-026 rsp_ready=1 while rsp_valid=0 SHALL have no effect.
REQ-027 A new request SHALL NOT be accepted in the same cycle its predecessor's response is consumed; the earliest re-accept is the next cycle. Maximum throughput is one transfer per WAIT_CYCLES+2 cycles.
REQ-028 Changes to req_* inputs after acceptance SHALL NOT affect the in-flight access.
REQ-029 A load from an address written by the immediately preceding store SHALL return the new data.
REQ-030 An address SHALL be compared against DEPTH at its full 8-bit width; no wrap-around or aliasing is permitted.

Reset
REQ-031 While reset=1, independent of clk: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1, and all DEPTH memory words=0.
REQ-032 Reset asserted during WAIT or RESP SHALL abort the transfer: a pending store SHALL NOT be written and no response SHALL be delivered.
REQ-033 After reset deasserts, the first rising edge with req_valid=1 SHALL accept a request.

Verification
REQ-034 With WAIT_CYCLES=2, store addr 0x10 data 0xBEEF, then load 0x10 -> store response: rdata 0xBEEF, err 0, 3 cycles after accept; load response: rdata 0xBEEF.
REQ-035 With WAIT_CYCLES=0, load 0x05 after reset -> rsp_valid in the cycle after accept, rdata 0x0000; back-to-back requests re-accepted one cycle after consume.
REQ-036 With DEPTH=16, store addr 0x20 data 0x1234, then load 0x00 and load 0x20 -> err=1 with rdata 0 for both 0x20 accesses; load 0x00 returns 0x0000, confirming no aliasing.
REQ-037 Hold rsp_ready=0 for 5 cycles, and change req_* during WAIT -> rsp_valid, rdata and err stable throughout; data matches the original request; req_ready=0 throughout.
REQ-038 Assert reset during WAIT of a store to 0x03 with data 0xAAAA, then load 0x03 -> rsp_valid drops immediately; load returns 0x0000.
REQ-039 Random stores and loads with random valid/ready stalls checked against a reference memory model -> zero mismatches, and req_ready=1 only when busy=0.
